// File: rtl/cpu_lr_stack.sv
// ---------------------------------------------------------------------------
// cpu_lr_stack
//
// Link-register return-address stack for the CPU jump unit. CALL pushes the
// return address (PC+1), RET pops it, and CALL+RET together performs a
// tail-call replacement of the top entry. The current top entry is presented
// combinationally on LR_ADDRESS so the jump unit can use it in the same cycle
// as RET.
//
// Parameters:
//   WIDTH  - address width (matches the jump unit)
//   DEPTH  - number of entries, power of two from 2 to 64
//
// Ports:
//   CLK         in   clock, all state changes on the rising edge
//   RST_N       in   asynchronous active-low reset
//   CALL        in   push request (saves PC+1)
//   RET         in   pop request (consumes the top entry)
//   PC          in   address of the executing instruction
//   CLR_ERR     in   clears the sticky OVF/UNF flags
//   LR_ADDRESS  out  top-of-stack return address, 0 when empty
//   COUNT       out  number of valid entries (0..DEPTH)
//   EMPTY       out  COUNT == 0
//   FULL        out  COUNT == DEPTH
//   OVF         out  sticky: push attempted while full
//   UNF         out  sticky: pop attempted while empty
//
// Configuration macro:
//   LR_STACK_WRAP_EN - when defined, a push while full overwrites the oldest
//                      entry (circular buffer); otherwise it is dropped.
//                      OVF is set in both cases.
// ---------------------------------------------------------------------------
module cpu_lr_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     CALL,
    input  logic                     RET,
    input  logic [WIDTH-1:0]         PC,
    input  logic                     CLR_ERR,
    output logic [WIDTH-1:0]         LR_ADDRESS,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic                     OVF,
    output logic                     UNF
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    // wr_ptr is the slot the next push lands in; the top entry sits just
    // below it. Both wrap modulo DEPTH, which is what lets the wrap build
    // overwrite the oldest entry simply by pushing into wr_ptr when full.
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] top_ptr;
    logic [PTR_W:0]   count_q;
    logic             ovf_q;
    logic             unf_q;

    logic             is_empty;
    logic             is_full;
    logic [WIDTH-1:0] ret_addr;

    logic             do_push;
    logic             do_pop;
    logic             do_replace;
    logic             set_ovf;
    logic             set_unf;
    logic             wr_en;
    logic [PTR_W-1:0] wr_addr;

    assign top_ptr  = wr_ptr - PTR_W'(1);
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == FULL_COUNT);
    assign ret_addr = PC + WIDTH'(1);

    // Operation decode. CALL+RET on an empty stack degenerates to a plain
    // push and must not flag underflow; CALL+RET on a full stack is a
    // replacement and never overflows.
    always_comb begin
        do_push    = 1'b0;
        do_pop     = 1'b0;
        do_replace = 1'b0;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        if (CALL && RET) begin
            if (is_empty) begin
                do_push = 1'b1;
            end else begin
                do_replace = 1'b1;
            end
        end else if (CALL) begin
            if (!is_full) begin
                do_push = 1'b1;
            end else begin
                set_ovf = 1'b1;
`ifdef LR_STACK_WRAP_EN
                do_push = 1'b1;
`endif
            end
        end else if (RET) begin
            if (is_empty) begin
                set_unf = 1'b1;
            end else begin
                do_pop = 1'b1;
            end
        end
    end

    assign wr_en   = do_push | do_replace;
    assign wr_addr = do_replace ? top_ptr : wr_ptr;

    // Storage is not reset: pointers and COUNT are, and LR_ADDRESS is
    // masked while empty, so stale contents can never leak out.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= ret_addr;
        end
    end

    // Pointer and count update. A push while full (wrap build only) still
    // advances the pointer but COUNT saturates at DEPTH.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (!is_full) begin
                    count_q <= count_q + (PTR_W + 1)'(1);
                end
            end else if (do_pop) begin
                wr_ptr  <= top_ptr;
                count_q <= count_q - (PTR_W + 1)'(1);
            end
        end
    end

    // Sticky error flags: a new error in the same cycle as CLR_ERR wins.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (set_ovf) begin
                ovf_q <= 1'b1;
            end else if (CLR_ERR) begin
                ovf_q <= 1'b0;
            end
            if (set_unf) begin
                unf_q <= 1'b1;
            end else if (CLR_ERR) begin
                unf_q <= 1'b0;
            end
        end
    end

    assign LR_ADDRESS = is_empty ? '0 : mem[top_ptr];
    assign COUNT      = count_q;
    assign EMPTY      = is_empty;
    assign FULL       = is_full;
    assign OVF        = ovf_q;
    assign UNF        = unf_q;

endmodule

// File: tb/tb_cpu_lr_stack.sv
// ---------------------------------------------------------------------------
// tb_cpu_lr_stack
//
// Scoreboard bench for cpu_lr_stack (WIDTH=8, DEPTH=8). The stimulus process
// drives one operation per cycle and queues the values the stack must show
// during that cycle; a separate monitor drains the queue on each falling
// edge (or immediately on request, for the asynchronous reset check).
// Expectations follow LR_STACK_WRAP_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_cpu_lr_stack;

    localparam int SEL_LR    = 0;
    localparam int SEL_COUNT = 1;
    localparam int SEL_EMPTY = 2;
    localparam int SEL_FULL  = 3;
    localparam int SEL_OVF   = 4;
    localparam int SEL_UNF   = 5;

    typedef struct {
        string name;
        int    sel;
        int    value;
    } exp_t;

    logic       CLK;
    logic       RST_N;
    logic       CALL;
    logic       RET;
    logic [7:0] PC;
    logic       CLR_ERR;
    logic [7:0] LR_ADDRESS;
    logic [3:0] COUNT;
    logic       EMPTY;
    logic       FULL;
    logic       OVF;
    logic       UNF;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    event sample_now;

    cpu_lr_stack #(.WIDTH(8), .DEPTH(8)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .CALL       (CALL),
        .RET        (RET),
        .PC         (PC),
        .CLR_ERR    (CLR_ERR),
        .LR_ADDRESS (LR_ADDRESS),
        .COUNT      (COUNT),
        .EMPTY      (EMPTY),
        .FULL       (FULL),
        .OVF        (OVF),
        .UNF        (UNF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Queue one expected value for the cycle currently being driven
    task automatic expect_val(input string name, input int sel, input int value);
        exp_t e;
        e.name  = name;
        e.sel   = sel;
        e.value = value;
        sb.push_back(e);
    endtask

    // Drive one cycle's inputs just after the rising edge; they take
    // effect on the following edge
    task automatic applyStimulus(input logic c, input logic r, input logic [7:0] pc,
                                 input logic clr);
        @(posedge CLK);
        #1;
        CALL    = c;
        RET     = r;
        PC      = pc;
        CLR_ERR = clr;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // Compare one queued expectation against the live DUT outputs
    task automatic checkOutput(input exp_t e);
        int act;
        case (e.sel)
            SEL_LR:    act = int'(LR_ADDRESS);
            SEL_COUNT: act = int'(COUNT);
            SEL_EMPTY: act = int'(EMPTY);
            SEL_FULL:  act = int'(FULL);
            SEL_OVF:   act = int'(OVF);
            default:   act = int'(UNF);
        endcase
        checks++;
        if (act != e.value) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", e.name, act, e.value, $time);
        end
    endtask

    // Monitor: drain every pending expectation mid-cycle or on demand
    initial begin
        forever begin
            @(negedge CLK or sample_now);
            while (sb.size() > 0) begin
                checkOutput(sb.pop_front());
            end
        end
    end

    initial begin
        RST_N   = 1'b0;
        CALL    = 1'b0;
        RET     = 1'b0;
        PC      = 8'h00;
        CLR_ERR = 1'b0;

        expect_val("reset_count", SEL_COUNT, 0);
        expect_val("reset_empty", SEL_EMPTY, 1);
        expect_val("reset_full",  SEL_FULL,  0);
        expect_val("reset_ovf",   SEL_OVF,   0);
        expect_val("reset_unf",   SEL_UNF,   0);
        expect_val("reset_lr",    SEL_LR,    0);
        @(negedge CLK);
        #2;
        RST_N = 1'b1;

        // Single call after reset
        applyStimulus(1'b1, 1'b0, 8'h10, 1'b0);
        idle();
        expect_val("call1_lr",    SEL_LR,    8'h11);
        expect_val("call1_count", SEL_COUNT, 1);
        expect_val("call1_empty", SEL_EMPTY, 0);

        // Nested calls, then three returns
        applyStimulus(1'b1, 1'b0, 8'h20, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h30, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        expect_val("ret1_lr",    SEL_LR,    8'h31);
        expect_val("ret1_count", SEL_COUNT, 3);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        expect_val("ret2_lr", SEL_LR, 8'h21);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        expect_val("ret3_lr", SEL_LR, 8'h11);
        idle();
        expect_val("nest_empty", SEL_EMPTY, 1);
        expect_val("nest_lr",    SEL_LR,    0);
        expect_val("nest_count", SEL_COUNT, 0);

        // Underflow, clear, and set-wins-over-clear
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        idle();
        expect_val("unf_set",   SEL_UNF,   1);
        expect_val("unf_count", SEL_COUNT, 0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        idle();
        expect_val("unf_clr", SEL_UNF, 0);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
        idle();
        expect_val("unf_setwins", SEL_UNF, 1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

        // CALL+RET while empty behaves as a push, no underflow
        applyStimulus(1'b1, 1'b1, 8'h05, 1'b0);
        idle();
        expect_val("cr_empty_count", SEL_COUNT, 1);
        expect_val("cr_empty_lr",    SEL_LR,    8'h06);
        expect_val("cr_empty_unf",   SEL_UNF,   0);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);

        // Fill to DEPTH, then one more push
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(i), 1'b0);
        end
        idle();
        expect_val("fill_full",  SEL_FULL,  1);
        expect_val("fill_count", SEL_COUNT, 8);
        expect_val("fill_lr",    SEL_LR,    8'h08);
        expect_val("fill_ovf",   SEL_OVF,   0);
        applyStimulus(1'b1, 1'b0, 8'h40, 1'b0);
        idle();
        expect_val("ovf_set",   SEL_OVF,   1);
        expect_val("ovf_count", SEL_COUNT, 8);
`ifdef LR_STACK_WRAP_EN
        expect_val("ovf_lr", SEL_LR, 8'h41);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        expect_val("drain_lr0", SEL_LR, 8'h41);
        for (int k = 1; k < 8; k++) begin
            applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
            expect_val("drain_lr", SEL_LR, 9 - k);
        end
`else
        expect_val("ovf_lr", SEL_LR, 8'h08);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
            expect_val("drain_lr", SEL_LR, 8 - k);
        end
`endif
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        expect_val("drain_empty", SEL_EMPTY, 1);
        idle();
        expect_val("ovf_clr", SEL_OVF, 0);

        // Tail call replaces the top entry
        applyStimulus(1'b1, 1'b0, 8'h10, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h50, 1'b0);
        idle();
        expect_val("tail_count", SEL_COUNT, 1);
        expect_val("tail_lr",    SEL_LR,    8'h51);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);

        // PC+1 wraps from 0xFF to 0x00
        applyStimulus(1'b1, 1'b0, 8'hFF, 1'b0);
        idle();
        expect_val("pcwrap_lr",    SEL_LR,    8'h00);
        expect_val("pcwrap_count", SEL_COUNT, 1);
        expect_val("pcwrap_empty", SEL_EMPTY, 0);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);

        // Asynchronous reset between edges with three entries held
        applyStimulus(1'b1, 1'b0, 8'h01, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h02, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h03, 1'b0);
        idle();
        expect_val("pre_rst_count", SEL_COUNT, 3);
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        expect_val("arst_count", SEL_COUNT, 0);
        expect_val("arst_lr",    SEL_LR,    0);
        expect_val("arst_empty", SEL_EMPTY, 1);
        -> sample_now;
        @(negedge CLK);
        #2;
        RST_N = 1'b1;

        // First edge after reset release processes CALL normally
        applyStimulus(1'b1, 1'b0, 8'h70, 1'b0);
        idle();
        expect_val("post_rst_lr",    SEL_LR,    8'h71);
        expect_val("post_rst_count", SEL_COUNT, 1);

        @(negedge CLK);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
